// File: rtl/ppu_write_arbiter.sv
// ppu_write_arbiter
// Merges the per-core pixel write streams of the PPU array into one
// framebuffer write port. Each core feeds a small FIFO (cores have no
// backpressure). A round-robin scheduler drains the FIFOs into a single
// registered ready/valid output stage.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/addr/data  per-core write streams, flattened core-major
//                       (core i occupies slice [i*W +: W])
//   mem_valid/ready     output handshake
//   mem_addr/data/src   output beat: address, colour, originating core
//   idle                all FIFOs empty and no beat presented
//   overflow            sticky per-core drop flags
//   clear_overflow      synchronous clear of overflow (a same-cycle drop wins)
module ppu_write_arbiter #(
  parameter int CORES_COUNT   = 10,
  parameter int COLOR_WIDTH   = 16,
  parameter int BUFFER_ADDR_W = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int SRC_W         = $clog2(CORES_COUNT)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [CORES_COUNT-1:0]             in_valid,
  input  logic [CORES_COUNT*BUFFER_ADDR_W-1:0] in_addr,
  input  logic [CORES_COUNT*COLOR_WIDTH-1:0] in_data,
  output logic                               mem_valid,
  input  logic                               mem_ready,
  output logic [BUFFER_ADDR_W-1:0]           mem_addr,
  output logic [COLOR_WIDTH-1:0]             mem_data,
  output logic [SRC_W-1:0]                   mem_src,
  output logic                               idle,
  output logic [CORES_COUNT-1:0]             overflow,
  input  logic                               clear_overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = BUFFER_ADDR_W + COLOR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W:0]   CORES_EXT = (SRC_W+1)'(CORES_COUNT);
  localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(CORES_COUNT - 1);

  logic [CORES_COUNT-1:0] nonempty;
  logic [CORES_COUNT-1:0] pop;
  logic [CORES_COUNT-1:0] drop;
  logic [ENTRY_W-1:0]     head_entry [CORES_COUNT];

  logic                     load_en;
  logic                     grant_valid;
  logic [SRC_W-1:0]         grant_idx;
  logic [SRC_W:0]           cand;
  logic [ENTRY_W-1:0]       grant_entry;

  logic                     mem_valid_reg;
  logic [BUFFER_ADDR_W-1:0] mem_addr_reg;
  logic [COLOR_WIDTH-1:0]   mem_data_reg;
  logic [SRC_W-1:0]         mem_src_reg;
  logic [SRC_W-1:0]         rr_ptr_reg;
  logic [CORES_COUNT-1:0]   overflow_reg;

  // Output stage can take a new beat when empty or when its beat leaves now.
  assign load_en = !mem_valid_reg || mem_ready;

  // ---------------------------------------------------------------------
  // Per-core FIFOs
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < CORES_COUNT; gi++) begin : g_core
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               push;

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign push     = in_valid[gi] && ((count_reg != DEPTH_CNT) || pop[gi]);
    assign drop[gi] = in_valid[gi] && !push;
    assign pop[gi]  = load_en && grant_valid && (grant_idx == SRC_W'(gi));
    assign nonempty[gi]   = (count_reg != '0);
    assign head_entry[gi] = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push, pop[gi]})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end

    // Storage needs no reset: count_reg alone defines which entries are live.
    always_ff @(posedge clk) begin
      if (push) begin
        fifo_mem[wr_ptr_reg] <= {in_addr[gi*BUFFER_ADDR_W +: BUFFER_ADDR_W],
                                 in_data[gi*COLOR_WIDTH +: COLOR_WIDTH]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin search starting at rr_ptr, wrapping circularly
  // ---------------------------------------------------------------------
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < CORES_COUNT; k++) begin
      cand = {1'b0, rr_ptr_reg} + (SRC_W+1)'(k);
      if (cand >= CORES_EXT) cand = cand - CORES_EXT;
      if (!grant_valid && nonempty[cand[SRC_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SRC_W-1:0];
      end
    end
  end

  assign grant_entry = head_entry[grant_idx];

  // ---------------------------------------------------------------------
  // Output register and scheduler pointer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
      mem_src_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        mem_valid_reg <= 1'b1;
        mem_addr_reg  <= grant_entry[ENTRY_W-1:COLOR_WIDTH];
        mem_data_reg  <= grant_entry[COLOR_WIDTH-1:0];
        mem_src_reg   <= grant_idx;
        rr_ptr_reg    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end else begin
        // Nothing queued: retire the beat, keep payload and pointer as-is.
        mem_valid_reg <= 1'b0;
      end
    end
  end

  // Drop in the same cycle as a clear leaves that bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg <= '0;
    end else if (clear_overflow) begin
      overflow_reg <= drop;
    end else begin
      overflow_reg <= overflow_reg | drop;
    end
  end

  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_data  = mem_data_reg;
  assign mem_src   = mem_src_reg;
  assign overflow  = overflow_reg;
  assign idle      = !(|nonempty) && !mem_valid_reg;

endmodule

// File: doc/ppu_write_arbiter.md
Name: ppu_write_arbiter

Overview:
- Merges the per-core pixel write streams from the PPU array into one framebuffer write port.
- Each PPU core emits at most one (address, colour) write per cycle and has no backpressure. The block therefore buffers each core in a small FIFO.
- A fair round-robin scheduler drains the FIFOs into a single registered ready/valid master port.
- Drops on a full FIFO are counted as sticky per-core overflow flags.

Parameters:
- CORES_COUNT, 10, number of PPU write streams.
- COLOR_WIDTH, 16, pixel data width.
- BUFFER_ADDR_W, 32, framebuffer address width.
- FIFO_DEPTH, 4, entries per core FIFO; power of two, at least 2.
- SRC_W, $clog2(CORES_COUNT), width of the source-index field.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- in_valid  in  [CORES_COUNT] x 1  per-core write strobe.
- in_addr  in  [CORES_COUNT] x BUFFER_ADDR_W  per-core write address.
- in_data  in  [CORES_COUNT] x COLOR_WIDTH  per-core pixel colour.
- mem_valid  out  1  output write valid.
- mem_ready  in  1  framebuffer accepts the write.
- mem_addr  out  BUFFER_ADDR_W  output write address.
- mem_data  out  COLOR_WIDTH  output write data.
- mem_src  out  SRC_W  index of the core that produced the current beat.
- idle  out  1  all FIFOs empty and mem_valid low.
- overflow  out  CORES_COUNT  sticky per-core drop flags.
- clear_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset:
  - Reset is asynchronous, active-low on reset_n; the clock is clk.
  - During reset: FIFOs empty, rr_ptr=0, mem_valid=0, mem_addr=0, mem_data=0, mem_src=0, overflow=0, idle=1.
  - Asserting reset mid-operation discards all buffered and in-flight beats; no partial write is presented after reset release.
- Push:
  - in_valid[i] is sampled at each rising edge.
  - The push is accepted if count[i] < FIFO_DEPTH, or if FIFO i is popped in the same cycle (push and pop on a full FIFO: count unchanged, no drop).
  - Otherwise the beat is dropped and overflow[i] is set at that edge.
- Output register: a single stage holds {addr, data, src}. It may load when empty, or when mem_valid && mem_ready in the current cycle, so full throughput is one beat per cycle.
- Arbitration (combinational, every cycle the output register may load):
  - Search cores rr_ptr, rr_ptr+1, ... CORES_COUNT-1, then 0 ... rr_ptr-1 (circular). Grant the first core with a non-empty FIFO.
  - On grant g: pop FIFO g, load the output register, and set rr_ptr <= (g+1) mod CORES_COUNT.
  - If no FIFO is non-empty: rr_ptr is unchanged; mem_valid is cleared if the current beat is consumed.
- Handshake:
  - Once mem_valid=1, mem_addr, mem_data and mem_src hold stable until the cycle mem_valid && mem_ready.
  - mem_valid never drops without a handshake.
- Latency: with an empty pipeline, in_valid high in cycle c gives mem_valid high in cycle c+2 (FIFO write at edge c, output register load at edge c+1).
- Capacity per core before a drop, with mem_ready held low: FIFO_DEPTH, plus 1 if that core wins the empty output register.
- Counters: count[i] is 0..FIFO_DEPTH. Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- overflow:
  - clear_overflow=1 clears all bits at the edge.
  - A drop in the same cycle as a clear wins: that bit ends set.
- idle: combinational = (all count==0) && !mem_valid.
- No ordering guarantee across cores. Per-core order is strictly FIFO.

Test Plan:
1. Single beat: after reset, core 3 pulses in_valid with addr=0x100, data=0xABCD; mem_ready=1 -> mem_valid exactly 2 cycles later with addr=0x100, data=0xABCD, src=3, high for 1 cycle; idle returns to 1 on the next cycle.
2. Simultaneous inputs: all 10 cores push one beat in the same cycle with addr=i; mem_ready=1 -> 10 consecutive beats with src 0,1,...,9; no overflow; rr_ptr ends at 0.
3. Fairness: cores 0 and 1 push every cycle; mem_ready=1 -> output src alternates 0,1,0,1; within each core, addresses appear in push order.
4. Backpressure and overflow: mem_ready=0; core 5 pushes 6 beats addr=0..5 -> the output register holds addr 0 stable; FIFO holds addr 1..4; addr 5 is dropped and overflow[5]=1. Release mem_ready -> addr 0..4 are delivered in order, then idle=1.
5. Full push+pop: FIFO of core 2 full and mem_ready=1 while core 2 pushes continuously -> no overflow; one beat per cycle out.
6. Reset and clear: reset_n is asserted mid-burst -> mem_valid=0 immediately, overflow=0. Then clear_overflow is asserted in the same cycle as a drop on core 7 -> overflow[7] stays 1.
